// File: rtl/fwd_hazard_unit.sv
// Decode-stage forwarding-select and load-use stall controller.
// Tracks EXE/MEM destination shadows and steers the operand A/B forwarding muxes.
module fwd_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rn,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             flush,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             stall,
  output logic [REG_W-1:0] e_rn,
  output logic             e_wreg,
  output logic [REG_W-1:0] m_rn,
  output logic             m_wreg,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] SEL_QA  = 2'b00;
  localparam logic [1:0] SEL_EXE = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_MDO = 2'b11;

  // Shadow pipeline state for the EXE and MEM stages
  logic [REG_W-1:0] e_rn_reg, e_rn_next;
  logic             e_wreg_reg, e_wreg_next;
  logic             e_m2reg_reg, e_m2reg_next;
  logic [REG_W-1:0] m_rn_reg;
  logic             m_wreg_reg;
  logic             m_m2reg_reg;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  // Per-operand view: index 0 is operand A (rs), index 1 is operand B (rt)
  logic [2*REG_W-1:0] src_idx;
  logic [1:0]         src_use;
  logic [3:0]         sel_flat;
  logic [1:0]         haz;
  logic               bubble;

  assign src_idx = {id_rt, id_rs};
  assign src_use = {id_use_rt, id_use_rs};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      logic [REG_W-1:0] src;
      logic             src_live;
      logic             match_e;
      logic             match_m;

      assign src      = src_idx[gi*REG_W +: REG_W];
      // r0 is hard-wired zero, so it is never a forwarding or stall source
      assign src_live = src_use[gi] & (src != '0);
      assign match_e  = src_live & e_wreg_reg & (e_rn_reg == src);
      assign match_m  = src_live & m_wreg_reg & (m_rn_reg == src);

      assign haz[gi] = match_e & e_m2reg_reg;

      // EXE is checked first so the youngest producer wins
      assign sel_flat[2*gi +: 2] =
          match_e ? (e_m2reg_reg ? SEL_QA  : SEL_EXE) :
          match_m ? (m_m2reg_reg ? SEL_MDO : SEL_MEM) :
                    SEL_QA;
    end
  endgenerate

  assign fwda  = sel_flat[1:0];
  assign fwdb  = sel_flat[3:2];
  assign stall = id_valid & ~flush & (|haz);

  assign bubble = stall | flush | ~id_valid;

  always_comb begin
    e_rn_next    = id_rn;
    e_wreg_next  = id_wreg;
    e_m2reg_next = id_m2reg;
    if (bubble) begin
      e_rn_next    = '0;
      e_wreg_next  = 1'b0;
      e_m2reg_next = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_next = stall_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_rn_reg      <= '0;
      e_wreg_reg    <= 1'b0;
      e_m2reg_reg   <= 1'b0;
      m_rn_reg      <= '0;
      m_wreg_reg    <= 1'b0;
      m_m2reg_reg   <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      m_rn_reg      <= e_rn_reg;
      m_wreg_reg    <= e_wreg_reg;
      m_m2reg_reg   <= e_m2reg_reg;
      e_rn_reg      <= e_rn_next;
      e_wreg_reg    <= e_wreg_next;
      e_m2reg_reg   <= e_m2reg_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign e_rn      = e_rn_reg;
  assign e_wreg    = e_wreg_reg;
  assign m_rn      = m_rn_reg;
  assign m_wreg    = m_wreg_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule
